// File: rtl/tm1638_responder.sv
// TM1638-style serial slave: receives command/data bytes on a 3-wire bus,
// keeps a 16-byte display RAM and display control, and shifts key-scan data back.
module tm1638_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int KEY_BYTES   = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_SPI_Stb,
  input  logic                   i_SPI_Clk,
  inout  wire                    io_SPI_Dio,
  input  logic [8*KEY_BYTES-1:0] i_Keys,
  input  logic [3:0]             i_Ram_Addr,
  output logic [7:0]             o_Ram_Data,
  output logic                   o_Display_On,
  output logic [2:0]             o_Brightness,
  output logic                   o_Frame_Done,
  output logic                   o_Key_Read,
  output logic                   o_Diag_Dio_Oe,
  output logic [1:0]             o_Diag_State
);

  localparam int KEY_BITS = 8 * KEY_BYTES;
  localparam int IDX_W    = $clog2(KEY_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  // Handshake: a byte is accepted on the detected SPI_Clk rising edge that
  // completes its 8th bit; read data is presented after each detected falling edge.

  logic [SYNC_STAGES-1:0] stb_sync_q, clk_sync_q, dio_sync_q;
  logic                   stb_prev_q, clk_prev_q;
  state_t                 state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic [3:0]             ptr_q;
  logic                   fixed_q;
  logic                   wrote_q;
  logic [7:0]             ram_q [16];
  logic                   disp_on_q;
  logic [2:0]             bright_q;
  logic                   frame_done_q;
  logic                   key_read_q;
  logic [KEY_BITS-1:0]    snap_q;
  logic [IDX_W-1:0]       rd_idx_q;
  logic                   rd_done_q;
  logic                   oe_q;
  logic                   dout_q;

  logic       stb_s, clk_s, dio_s;
  logic       stb_rise, stb_fall, clk_rise, clk_fall;
  logic [7:0] byte_d;
  logic       byte_done;

  // Strobe synchronizer resets low so a strobe still held low after reset
  // cannot look like a fresh falling edge.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      stb_sync_q <= '0;
      clk_sync_q <= '1;
      dio_sync_q <= '1;
      stb_prev_q <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], i_SPI_Stb};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
      dio_sync_q <= {dio_sync_q[SYNC_STAGES-2:0], io_SPI_Dio};
      stb_prev_q <= stb_s;
      clk_prev_q <= clk_s;
    end
  end

  always_comb begin
    stb_s     = stb_sync_q[SYNC_STAGES-1];
    clk_s     = clk_sync_q[SYNC_STAGES-1];
    dio_s     = dio_sync_q[SYNC_STAGES-1];
    stb_rise  = stb_s & ~stb_prev_q;
    stb_fall  = ~stb_s & stb_prev_q;
    clk_rise  = clk_s & ~clk_prev_q & ~stb_s;
    clk_fall  = ~clk_s & clk_prev_q & ~stb_s;
    byte_d    = {dio_s, shift_q[7:1]};
    byte_done = clk_rise && (bit_cnt_q == 3'd7);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      ptr_q        <= 4'd0;
      fixed_q      <= 1'b0;
      wrote_q      <= 1'b0;
      for (int i = 0; i < 16; i++) ram_q[i] <= 8'h00;
      disp_on_q    <= 1'b0;
      bright_q     <= 3'd0;
      frame_done_q <= 1'b0;
      key_read_q   <= 1'b0;
      snap_q       <= '0;
      rd_idx_q     <= '0;
      rd_done_q    <= 1'b0;
      oe_q         <= 1'b0;
      dout_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      key_read_q   <= 1'b0;
      if (stb_rise) begin
        // End of transaction wins over any clock edge seen in the same cycle.
        state_q      <= ST_IDLE;
        bit_cnt_q    <= 3'd0;
        shift_q      <= 8'h00;
        oe_q         <= 1'b0;
        rd_done_q    <= 1'b0;
        rd_idx_q     <= '0;
        frame_done_q <= wrote_q;
        wrote_q      <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (stb_fall) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= 3'd0;
            end
          end
          ST_CMD: begin
            if (clk_rise) begin
              shift_q   <= byte_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
              case (byte_d[7:6])
                2'b01: begin
                  if (byte_d[1]) begin
                    snap_q     <= i_Keys;
                    key_read_q <= 1'b1;
                    rd_idx_q   <= '0;
                    rd_done_q  <= 1'b0;
                    oe_q       <= 1'b0;
                    state_q    <= ST_READ;
                  end else begin
                    fixed_q <= byte_d[2];
                  end
                end
                2'b10: begin
                  disp_on_q <= byte_d[3];
                  bright_q  <= byte_d[2:0];
                end
                2'b11: begin
                  ptr_q   <= byte_d[3:0];
                  state_q <= ST_WRITE;
                end
                default: ;
              endcase
            end
          end
          ST_WRITE: begin
            if (clk_rise) begin
              shift_q   <= byte_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
              ram_q[ptr_q] <= byte_d;
              wrote_q      <= 1'b1;
              if (!fixed_q) ptr_q <= ptr_q + 4'd1;
            end
          end
          ST_READ: begin
            if (!rd_done_q) begin
              if (clk_fall) begin
                oe_q   <= 1'b1;
                dout_q <= snap_q[rd_idx_q];
              end else if (clk_rise && oe_q) begin
                if (rd_idx_q == IDX_W'(KEY_BITS - 1)) begin
                  oe_q      <= 1'b0;
                  rd_done_q <= 1'b1;
                end else begin
                  rd_idx_q <= rd_idx_q + 1'b1;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign io_SPI_Dio    = oe_q ? dout_q : 1'bz;
  assign o_Ram_Data    = ram_q[i_Ram_Addr];
  assign o_Display_On  = disp_on_q;
  assign o_Brightness  = bright_q;
  assign o_Frame_Done  = frame_done_q;
  assign o_Key_Read    = key_read_q;
  assign o_Diag_Dio_Oe = oe_q;
  assign o_Diag_State  = state_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: a bit-banged bus master plus a byte-level model
// of display RAM, display control and key-scan readout.
module tb_tm1638_responder;

  localparam int HP = 6;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_SPI_Stb = 1'b1;
  logic        i_SPI_Clk = 1'b1;
  wire         io_SPI_Dio;
  logic [31:0] i_Keys = 32'h0;
  logic [3:0]  i_Ram_Addr = 4'd0;
  logic [7:0]  o_Ram_Data;
  logic        o_Display_On;
  logic [2:0]  o_Brightness;
  logic        o_Frame_Done;
  logic        o_Key_Read;
  logic        o_Diag_Dio_Oe;
  logic [1:0]  o_Diag_State;

  logic m_oe  = 1'b1;
  logic m_dio = 1'b1;
  assign io_SPI_Dio = m_oe ? m_dio : 1'bz;

  tm1638_responder #(.SYNC_STAGES(2), .KEY_BYTES(4)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_SPI_Stb(i_SPI_Stb), .i_SPI_Clk(i_SPI_Clk),
    .io_SPI_Dio(io_SPI_Dio), .i_Keys(i_Keys), .i_Ram_Addr(i_Ram_Addr),
    .o_Ram_Data(o_Ram_Data), .o_Display_On(o_Display_On), .o_Brightness(o_Brightness),
    .o_Frame_Done(o_Frame_Done), .o_Key_Read(o_Key_Read),
    .o_Diag_Dio_Oe(o_Diag_Dio_Oe), .o_Diag_State(o_Diag_State)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_fail = 0;
  int fd_seen = 0;
  int kr_seen = 0;
  int exp_fd = 0;
  int exp_kr = 0;

  always @(negedge i_Clk) begin
    if (o_Frame_Done) fd_seen++;
    if (o_Key_Read) kr_seen++;
  end

  // Reference model of the slave's visible state.
  logic [7:0] m_ram [16];
  logic       m_fixed;
  logic       m_disp;
  logic [2:0] m_bright;
  logic [7:0] txq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_fixed = 1'b0;
    m_disp = 1'b0;
    m_bright = 3'd0;
  endtask

  // Interprets a full transaction byte list the way the bus protocol defines it.
  task automatic model_apply();
    bit in_data = 0;
    int ptr = 0;
    int nwr = 0;
    foreach (txq[i]) begin
      if (!in_data) begin
        case (txq[i][7:6])
          2'b01: if (!txq[i][1]) m_fixed = txq[i][2];
          2'b10: begin m_disp = txq[i][3]; m_bright = txq[i][2:0]; end
          2'b11: begin ptr = int'(txq[i][3:0]); in_data = 1; end
          default: ;
        endcase
      end else begin
        m_ram[ptr] = txq[i];
        nwr++;
        if (!m_fixed) ptr = (ptr + 1) % 16;
      end
    end
    if (nwr > 0) exp_fd++;
  endtask

  task automatic stb_begin();
    tick(1);
    i_SPI_Stb = 1'b0;
    tick(HP);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      i_SPI_Clk = 1'b0;
      m_oe = 1'b1;
      m_dio = b[i];
      tick(HP);
      i_SPI_Clk = 1'b1;
      tick(HP);
    end
  endtask

  task automatic stb_end();
    i_SPI_Stb = 1'b1;
    tick(HP + 4);
  endtask

  task automatic run_txn();
    stb_begin();
    foreach (txq[i]) send_bits(txq[i], 8);
    stb_end();
    model_apply();
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < 16; a++) begin
      i_Ram_Addr = 4'(a);
      #1;
      check($sformatf("%s_ram%0d", tag, a), {24'h0, o_Ram_Data}, {24'h0, m_ram[a]});
    end
  endtask

  task automatic check_disp(input string tag);
    check({tag, "_on"}, {31'h0, o_Display_On}, {31'h0, m_disp});
    check({tag, "_bright"}, {29'h0, o_Brightness}, {29'h0, m_bright});
  endtask

  task automatic key_read(input string tag, input logic [31:0] keys);
    logic [31:0] got;
    got = 32'h0;
    i_Keys = keys;
    stb_begin();
    send_bits(8'h42, 8);
    m_oe = 1'b0;
    exp_kr++;
    tick(2);
    check({tag, "_state_read"}, {30'h0, o_Diag_State}, 32'd3);
    for (int i = 0; i < 32; i++) begin
      i_SPI_Clk = 1'b0;
      tick(HP);
      if (i == 0) check({tag, "_oe_on"}, {31'h0, o_Diag_Dio_Oe}, 32'd1);
      got[i] = io_SPI_Dio;
      i_SPI_Clk = 1'b1;
      tick(HP);
    end
    check({tag, "_oe_off"}, {31'h0, o_Diag_Dio_Oe}, 32'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_byte%0d", tag, k), {24'h0, got[8*k +: 8]}, (keys >> (8 * k)) & 32'hFF);
    // Further clocks after the last bit must leave the line released.
    i_SPI_Clk = 1'b0;
    tick(HP);
    check({tag, "_oe_extra"}, {31'h0, o_Diag_Dio_Oe}, 32'd0);
    i_SPI_Clk = 1'b1;
    tick(HP);
    stb_end();
    check({tag, "_kr_count"}, kr_seen, exp_kr);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  r;
    logic [31:0] keys;
    model_reset();
    tick(3);
    check("rst_oe", {31'h0, o_Diag_Dio_Oe}, 32'd0);
    check("rst_state", {30'h0, o_Diag_State}, 32'd0);
    check("rst_fd", {31'h0, o_Frame_Done}, 32'd0);
    check("rst_kr", {31'h0, o_Key_Read}, 32'd0);
    check_disp("rst");
    i_Rst = 1'b0;
    tick(6);
    check_ram("rst");

    // Three bytes in auto-increment mode from address 0.
    txq = {8'h40}; run_txn();
    txq = {8'hC0, 8'h3F, 8'h06, 8'h5B}; run_txn();
    check_ram("auto");
    check("auto_fd", fd_seen, exp_fd);

    // Fixed-address mode overwrites one location; auto mode wraps 15 -> 0.
    txq = {8'h44}; run_txn();
    txq = {8'hCF, 8'h11, 8'h22}; run_txn();
    check_ram("fixed");
    txq = {8'h40}; run_txn();
    txq = {8'hCF, 8'h11, 8'h22}; run_txn();
    check_ram("wrap");
    check("wrap_fd", fd_seen, exp_fd);

    // Display control, then an ignored command.
    txq = {8'h8A}; run_txn();
    check_disp("dispctl");
    txq = {8'h00}; run_txn();
    check_disp("ignored");

    // Randomized mixed command/data transactions.
    for (int t = 0; t < 6; t++) begin
      txq = {8'h40 | (8'($urandom_range(0, 1)) << 2)};
      run_txn();
      txq = {};
      if ($urandom_range(0, 1) == 1) txq.push_back(8'h80 | 8'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) txq.push_back(8'h00);
      txq.push_back(8'hC0 | 8'($urandom_range(0, 15)));
      for (int n = 0; n < $urandom_range(1, 20); n++) begin
        r = 8'($urandom);
        txq.push_back(r);
      end
      run_txn();
      check_ram($sformatf("rnd%0d", t));
      check_disp($sformatf("rnd%0d", t));
      check($sformatf("rnd%0d_fd", t), fd_seen, exp_fd);
    end

    // Key readout: fixed image and a random one.
    key_read("keys", 32'h8001_A50F);
    keys = $urandom;
    key_read("keys_rnd", keys);
    check("keys_fd", fd_seen, exp_fd);

    // Aborted partial byte: nothing written, next transaction decodes normally.
    txq = {8'h40}; run_txn();
    stb_begin();
    send_bits(8'hC3, 8);
    send_bits(8'hFF, 5);
    stb_end();
    check_ram("partial");
    check("partial_fd", fd_seen, exp_fd);
    check("partial_state", {30'h0, o_Diag_State}, 32'd0);
    txq = {8'hC3, 8'hAA}; run_txn();
    check_ram("after_partial");
    check("after_partial_fd", fd_seen, exp_fd);

    // Reset in the middle of a key read.
    i_Keys = 32'hFFFF_FFFF;
    stb_begin();
    send_bits(8'h42, 8);
    m_oe = 1'b0;
    exp_kr++;
    for (int i = 0; i < 10; i++) begin
      i_SPI_Clk = 1'b0; tick(HP);
      i_SPI_Clk = 1'b1; tick(HP);
    end
    i_SPI_Clk = 1'b0;
    tick(HP);
    check("midrst_oe_before", {31'h0, o_Diag_Dio_Oe}, 32'd1);
    i_Rst = 1'b1;
    #2;
    check("midrst_oe", {31'h0, o_Diag_Dio_Oe}, 32'd0);
    model_reset();
    tick(2);
    check("midrst_state", {30'h0, o_Diag_State}, 32'd0);
    check("midrst_fd", {31'h0, o_Frame_Done}, 32'd0);
    check("midrst_kr", {31'h0, o_Key_Read}, 32'd0);
    check_disp("midrst");
    check_ram("midrst");
    i_Rst = 1'b0;
    tick(4);
    // Strobe still low: clocks must not restart the transaction.
    send_bits(8'hC0, 8);
    m_oe = 1'b0;
    check("midrst_idle", {30'h0, o_Diag_State}, 32'd0);
    check("midrst_idle_oe", {31'h0, o_Diag_Dio_Oe}, 32'd0);
    stb_end();
    check_ram("midrst_after");
    txq = {8'h40}; run_txn();
    txq = {8'hC5, 8'h77, 8'h88}; run_txn();
    check_ram("post_rst");
    check("post_rst_fd", fd_seen, exp_fd);
    check("post_rst_kr", kr_seen, exp_kr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tm1638_responder.md
TM1638_RESPONDER -- requirements
Module: tm1638_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops synchronizing each SPI input into the i_Clk domain (min 2).
REQ-002 SHALL have parameter KEY_BYTES, default 4, number of key-scan bytes returned per read command.
REQ-003 SHALL have port i_Clk  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port i_Rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_SPI_Stb  input  1  strobe from the TM1638 master; low marks an active transaction.
REQ-006 SHALL have port i_SPI_Clk  input  1  serial clock from the master; idles high.
REQ-007 SHALL have port io_SPI_Dio  inout  1  serial data; driven only while o_Diag_Dio_Oe=1, otherwise high-Z.
REQ-008 SHALL have port i_Keys  input  8*KEY_BYTES  key-scan image; bit 0 is the first serial bit.
REQ-009 SHALL have port i_Ram_Addr  input  4  display-RAM read address.
REQ-010 SHALL have port o_Ram_Data  output  8  display-RAM byte at i_Ram_Addr, combinational read.
REQ-011 SHALL have port o_Display_On  output  1  display-control on bit.
REQ-012 SHALL have port o_Brightness  output  3  display-control brightness.
REQ-013 SHALL have port o_Frame_Done  output  1  one-cycle pulse at the end of a transaction that wrote at least one RAM byte.
REQ-014 SHALL have port o_Key_Read  output  1  one-cycle pulse when a read command is accepted.
REQ-015 SHALL have port o_Diag_Dio_Oe  output  1  Dio output enable.
REQ-016 SHALL have port o_Diag_State  output  2  current FSM state encoding.

Function
REQ-017 SHALL synchronize Stb, Clk and Dio through SYNC_STAGES flops and detect edges on the synchronized values; all timing below refers to detected edges.
REQ-018 SHALL shift Dio LSB-first on each detected SPI_Clk rising edge while Stb is low; the 8th bit completes a byte.
REQ-019 SHALL implement states IDLE(0), CMD(1), WRITE(2), READ(3); Stb falling: IDLE->CMD; Stb rising from any state: ->IDLE, bit counter cleared, partial byte discarded.
REQ-020 SHALL decode the completed byte in CMD by bits[7:6]: 01 data command, 10 display control, 11 address set, 00 ignored.
REQ-021 SHALL, on data command with bit1=0, latch fixed-address mode = bit2 (persists across transactions) and stay in CMD.
REQ-022 SHALL, on data command with bit1=1, snapshot i_Keys, pulse o_Key_Read, and enter READ.
REQ-023 SHALL, on display control, set o_Display_On=bit3, o_Brightness=bits[2:0] in the next cycle, and stay in CMD.
REQ-024 SHALL, on address set, load the address pointer with bits[3:0] and enter WRITE.
REQ-025 SHALL, in WRITE, write each completed byte to RAM[pointer] in the cycle after the 8th rising edge; the pointer increments modulo 16 (15 wraps to 0) unless fixed-address mode.
REQ-026 SHALL, in READ, assert Oe and drive snapshot bit 0 at the first detected SPI_Clk falling edge, then the next bit at each subsequent falling edge.
REQ-027 SHALL, after the last bit (8*KEY_BYTES) is consumed by a rising edge, deassert Oe and ignore further clocks until Stb rises.
REQ-028 SHALL ignore SPI_Clk edges while Stb is high.
REQ-029 SHALL pulse o_Frame_Done on the cycle after Stb rising is detected if the transaction wrote at least one byte.
REQ-030 SHALL give Stb rising priority over a simultaneously detected SPI_Clk edge (the edge is discarded).

Reset
REQ-031 SHALL, on i_Rst, clear all RAM bytes to 0x00; o_Display_On=0, o_Brightness=0, auto-increment mode, pointer 0, state IDLE, Oe=0, o_Frame_Done=0, o_Key_Read=0.
REQ-032 SHALL, on reset assertion mid-transaction, abort the transaction immediately (Dio released, no partial write) and require a fresh Stb falling edge to resume.

Verification
REQ-033 Txn 0x40; txn 0xC0,0x3F,0x06,0x5B -> RAM[0..2]=3F,06,5B, others 00, one o_Frame_Done pulse.
REQ-034 Txn 0x44; txn 0xCF,0x11,0x22 -> RAM[15]=0x22, RAM[0]=00; repeat in auto mode with 0xCF,0x11,0x22 -> RAM[15]=0x11, RAM[0]=0x22.
REQ-035 i_Keys=0x8001_A50F, txn 0x42 then 32 clocks -> master samples 0x0F,0xA5,0x01,0x80 LSB-first, Oe low after bit 31, one o_Key_Read pulse.
REQ-036 Txn 0x8A -> o_Display_On=1, o_Brightness=2; txn 0x00 -> no output change.
REQ-037 Txn 0xC3 then 5 bits and Stb high -> RAM unchanged, no o_Frame_Done; next full txn decodes normally.
REQ-038 i_Rst pulsed during bit 10 of a key read -> Oe=0 within one cycle, all outputs at reset values.
